// File: rtl/lfsr_pkg.sv
// Shared defaults for the LFSR sample FIFO: sample width, FIFO depth and level width.
package lfsr_pkg;
    localparam int WIDTH_DEFAULT = 8;
    localparam int DEPTH_DEFAULT = 8;
    localparam int LEVEL_W       = $clog2(DEPTH_DEFAULT) + 1;
    localparam int DIV_W         = 4;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: array storage, wrapping pointers, and a registered
// head-of-queue output so the oldest entry is always presented on dout.
module sync_fifo
    import lfsr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
            // Head register: next stored entry on pop, or the incoming sample
            // when it becomes the head directly (bypassing the array).
            if (do_pop) begin
                if (level_reg > LW'(1)) begin
                    dout_reg <= mem[rd_ptr_reg + AW'(1)];
                end else if (do_push) begin
                    dout_reg <= din;
                end
            end else if (do_push && empty) begin
                dout_reg <= din;
            end
        end
    end

    assign dout  = dout_reg;
    assign level = level_reg;
endmodule

// File: rtl/lfsr_sample_fifo.sv
// Samples an upstream LFSR state every div+1 enabled cycles into a show-ahead FIFO,
// with a sticky overflow flag for samples dropped while full.
module lfsr_sample_fifo
    import lfsr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       lfsr_bits,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       div,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clear_ovf
);
    logic [DIV_W-1:0] count_reg;
    logic             overflow_reg;
    logic             strobe;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;

    // ">=" rather than "==" so lowering div below count strobes immediately.
    assign strobe = enable && (count_reg >= div);
    assign drop   = strobe && fifo_full && !(out_valid && out_ready);

    always_ff @(posedge clk) begin
        if (rst || !enable || strobe) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (clear_ovf) begin
            overflow_reg <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (strobe),
        .pop   (out_ready),
        .din   (lfsr_bits),
        .dout  (out_data),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_reg;
endmodule

// File: tb/tb_lfsr_sample_fifo.sv
// Directed and randomized checks of lfsr_sample_fifo against a queue-based model.
module tb_lfsr_sample_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] lfsr_bits = '0;
    logic             enable = 1'b0;
    logic [3:0]       div = '0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       level;
    logic             overflow;
    logic             clear_ovf = 1'b0;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [WIDTH-1:0] q[$];
    int               cnt_m = 0;
    bit               ovf_m = 0;
    bit               after_rst = 0;

    always #5 clk = ~clk;

    lfsr_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .lfsr_bits (lfsr_bits),
        .enable    (enable),
        .div       (div),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model by the sampling/FIFO rules, then compare.
    task automatic step();
        bit pop, strobe, was_full;
        @(posedge clk);
        if (rst) begin
            q.delete();
            cnt_m = 0;
            ovf_m = 0;
            after_rst = 1;
        end else begin
            pop      = (q.size() != 0) && out_ready;
            was_full = (q.size() == DEPTH);
            strobe   = enable && (cnt_m >= int'(div));
            if (!enable || strobe) cnt_m = 0;
            else cnt_m = cnt_m + 1;
            if (pop) void'(q.pop_front());
            if (strobe) begin
                if (was_full && !pop) ovf_m = 1;
                else q.push_back(lfsr_bits);
            end
            if (!(strobe && was_full && !pop) && clear_ovf) ovf_m = 0;
            if (pop || strobe) after_rst = 0;
        end
        #1;
        chk("level", 32'(level), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
        else if (after_rst) chk("out_data_rst", 32'(out_data), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        enable = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
        do_reset();
        chk("rst_level", 32'(level), 32'd0);

        // Every-cycle sampling with an always-ready consumer: one cycle late, level <= 1
        enable = 1'b1; div = 4'd0; out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            lfsr_bits = 8'(i);
            step();
            chk("follow_data", 32'(out_data), 32'(i));
            chk("follow_level_le1", 32'(level <= 4'd1), 32'd1);
        end

        // div=3 with stalled consumer: 4 pushes in 16 cycles
        do_reset();
        enable = 1'b1; div = 4'd3; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            lfsr_bits = 8'($urandom);
            step();
        end
        chk("div3_level", 32'(level), 32'd4);
        chk("div3_valid", 32'(out_valid), 32'd1);

        // Fill to full, then overflow; first entry must survive
        do_reset();
        enable = 1'b1; div = 4'd0; out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            lfsr_bits = 8'(8'h40 + i);
            step();
            if (i == 8) chk("full_level", 32'(level), 32'd8);
            if (i == 8) chk("full_no_ovf", 32'(overflow), 32'd0);
            if (i == 9) chk("ovf_set", 32'(overflow), 32'd1);
        end
        chk("ovf_head", 32'(out_data), 32'h41);
        clear_ovf = 1'b1;
        step();
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        enable = 1'b0;
        step();
        chk("ovf_cleared", 32'(overflow), 32'd0);
        clear_ovf = 1'b0;

        // Full with simultaneous strobe and pop: level holds, wrap ordering
        enable = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lfsr_bits = 8'($urandom);
            step();
            chk("full_pp_level", 32'(level), 32'd8);
            chk("full_pp_ovf", 32'(overflow), 32'd0);
        end

        // Reset mid-operation with level=5 and a strobe pending
        do_reset();
        enable = 1'b1; div = 4'd0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            lfsr_bits = 8'($urandom);
            step();
        end
        chk("pre_rst_level", 32'(level), 32'd5);
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        // count restarted at 0: with div=2, first push lands on the third edge
        div = 4'd2; out_ready = 1'b0;
        step(); step();
        chk("midrst_cnt_a", 32'(level), 32'd0);
        step();
        chk("midrst_cnt_b", 32'(level), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            enable    = ($urandom_range(0, 3) != 0);
            div       = 4'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) == 0);
            clear_ovf = ($urandom_range(0, 7) == 0);
            lfsr_bits = 8'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
